// File: rtl/long_maze_sys.sv
// 3x3 maze agent with zone decode, step budget, bump pulse and sticky done.
// Z6 at (0,0) is a trap; (0,1) and (0,2) are walls.
module long_maze_sys #(
    parameter int MAX_STEPS = 64,
    parameter int START_ROW = 1,
    parameter int START_COL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iupdown,
    input  logic       ileftright,
    input  logic       idir,
    output logic       controllable_zone1,
    output logic       controllable_zone2,
    output logic       controllable_zone3,
    output logic       controllable_zone4,
    output logic       controllable_zone5,
    output logic       controllable_zone6,
    output logic [1:0] orow,
    output logic [1:0] ocol,
    output logic [7:0] osteps,
    output logic       obump,
    output logic       odone
);

    localparam logic [7:0] MAX   = 8'(MAX_STEPS);
    localparam logic [1:0] SROW  = 2'(START_ROW);
    localparam logic [1:0] SCOL  = 2'(START_COL);
    localparam logic       SDONE = (START_ROW == 0) && (START_COL == 0);

    logic       accept;
    logic       blocked;
    logic       to_trap;
    logic [2:0] tr;
    logic [2:0] tc;
    logic [7:0] next_steps;

    assign accept = (iupdown ^ ileftright) && !odone;

    // Target is one bit wider so a step up/left from 0 wraps to 7, i.e. off-grid.
    always_comb begin
        tr = {1'b0, orow};
        tc = {1'b0, ocol};
        if (iupdown) begin
            tr = idir ? tr + 3'd1 : tr - 3'd1;
        end else begin
            tc = idir ? tc + 3'd1 : tc - 3'd1;
        end
        blocked = (tr > 3'd2) || (tc > 3'd2) || (tr == 3'd0 && tc != 3'd0);
        to_trap = !blocked && tr == 3'd0 && tc == 3'd0;
        next_steps = (osteps == MAX) ? osteps : osteps + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            orow   <= SROW;
            ocol   <= SCOL;
            osteps <= 8'd0;
            obump  <= 1'b0;
            odone  <= SDONE;
        end else begin
            obump <= 1'b0;
            if (accept) begin
                osteps <= next_steps;
                if (next_steps == MAX || to_trap) begin
                    odone <= 1'b1;
                end
                if (blocked) begin
                    obump <= 1'b1;
                end else begin
                    orow <= tr[1:0];
                    ocol <= tc[1:0];
                end
            end
        end
    end

    always_comb begin
        controllable_zone1 = (orow == 2'd1) && (ocol == 2'd1);
        controllable_zone2 = (orow == 2'd1) && (ocol == 2'd2);
        controllable_zone3 = (orow == 2'd2) && (ocol == 2'd2);
        controllable_zone4 = (orow == 2'd2) && (ocol == 2'd1);
        controllable_zone5 = (orow == 2'd2) && (ocol == 2'd0);
        controllable_zone6 = (orow == 2'd0) && (ocol == 2'd0);
    end

endmodule

// File: tb/tb_long_maze_sys.sv
// Directed vector table for the default maze plus a MAX_STEPS=4 budget sequence.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_long_maze_sys;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ud, lr, dir;
    logic [5:0] zone;
    logic [1:0] row, col;
    logic [7:0] steps;
    logic       bump, done;

    logic       b_rst, b_ud, b_lr, b_dir;
    logic [5:0] b_zone;
    logic [1:0] b_row, b_col;
    logic [7:0] b_steps;
    logic       b_bump, b_done;

    long_maze_sys dut (
        .clk(clk), .rst(rst), .iupdown(ud), .ileftright(lr), .idir(dir),
        .controllable_zone1(zone[0]), .controllable_zone2(zone[1]),
        .controllable_zone3(zone[2]), .controllable_zone4(zone[3]),
        .controllable_zone5(zone[4]), .controllable_zone6(zone[5]),
        .orow(row), .ocol(col), .osteps(steps), .obump(bump), .odone(done)
    );

    long_maze_sys #(.MAX_STEPS(4)) dut4 (
        .clk(clk), .rst(b_rst), .iupdown(b_ud), .ileftright(b_lr),
        .idir(b_dir),
        .controllable_zone1(b_zone[0]), .controllable_zone2(b_zone[1]),
        .controllable_zone3(b_zone[2]), .controllable_zone4(b_zone[3]),
        .controllable_zone5(b_zone[4]), .controllable_zone6(b_zone[5]),
        .orow(b_row), .ocol(b_col), .osteps(b_steps), .obump(b_bump),
        .odone(b_done)
    );

    typedef struct {
        logic       rst, ud, lr, dir;
        logic [1:0] row, col;
        logic [5:0] zone;
        logic [7:0] steps;
        logic       bump, done;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    // move codes: 0 idle, 1 up, 2 down, 3 left, 4 right, 5 both
    function automatic vec_t mk(logic r, int mv, int er, int ec, int ez,
                                int es, logic eb, logic ed);
        vec_t v;
        v.rst = r;
        v.ud  = (mv == 1 || mv == 2 || mv == 5);
        v.lr  = (mv == 3 || mv == 4 || mv == 5);
        v.dir = (mv == 2 || mv == 4);
        v.row = 2'(er);
        v.col = 2'(ec);
        v.zone = (ez == 0) ? 6'd0 : 6'(1 << (ez - 1));
        v.steps = 8'(es);
        v.bump = eb;
        v.done = ed;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic b_drive(logic r, int mv);
        b_rst = r;
        b_ud  = (mv == 1 || mv == 2 || mv == 5);
        b_lr  = (mv == 3 || mv == 4 || mv == 5);
        b_dir = (mv == 2 || mv == 4);
        @(negedge clk);
    endtask

    task automatic b_chk(string tag, int er, int ec, int es, logic eb,
                         logic ed);
        chk({tag, " row"}, b_row, er);
        chk({tag, " col"}, b_col, ec);
        chk({tag, " steps"}, b_steps, es);
        chk({tag, " bump"}, b_bump, eb);
        chk({tag, " done"}, b_done, ed);
    endtask

    initial begin
        rst = 1'b1; ud = 1'b0; lr = 1'b0; dir = 1'b0;
        b_rst = 1'b1; b_ud = 1'b0; b_lr = 1'b0; b_dir = 1'b0;

        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        // full tour right, right, down, left, left
        vecs.push_back(mk(0, 4, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4, 1, 2, 2, 2, 0, 0));
        vecs.push_back(mk(0, 2, 2, 2, 3, 3, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 4, 4, 0, 0));
        vecs.push_back(mk(0, 3, 2, 0, 5, 5, 0, 0));
        // back to start, bump tests
        vecs.push_back(mk(0, 1, 1, 0, 0, 6, 0, 0));
        vecs.push_back(mk(0, 4, 1, 1, 1, 7, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 8, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 8, 0, 0));
        vecs.push_back(mk(0, 4, 1, 2, 2, 9, 0, 0));
        vecs.push_back(mk(0, 2, 2, 2, 3, 10, 0, 0));
        vecs.push_back(mk(0, 2, 2, 2, 3, 11, 1, 0));
        vecs.push_back(mk(0, 4, 2, 2, 3, 12, 1, 0));
        vecs.push_back(mk(0, 0, 2, 2, 3, 12, 0, 0));
        // both requests for 5 cycles
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 5, 2, 2, 3, 12, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 4, 13, 0, 0));
        vecs.push_back(mk(0, 3, 2, 0, 5, 14, 0, 0));
        vecs.push_back(mk(0, 3, 2, 0, 5, 15, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16, 0, 0));
        vecs.push_back(mk(0, 3, 1, 0, 0, 17, 1, 0));
        // reset with a request, then trap
        vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 6, 1, 0, 1));
        vecs.push_back(mk(0, 2, 0, 0, 6, 1, 0, 1));
        vecs.push_back(mk(0, 2, 0, 0, 6, 1, 0, 1));
        vecs.push_back(mk(0, 2, 0, 0, 6, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 6, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4, 1, 1, 1, 1, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            ud  = vecs[i].ud;
            lr  = vecs[i].lr;
            dir = vecs[i].dir;
            @(negedge clk);
            chk($sformatf("v%0d row", i), row, vecs[i].row);
            chk($sformatf("v%0d col", i), col, vecs[i].col);
            chk($sformatf("v%0d zone", i), zone, vecs[i].zone);
            chk($sformatf("v%0d steps", i), steps, vecs[i].steps);
            chk($sformatf("v%0d bump", i), bump, vecs[i].bump);
            chk($sformatf("v%0d done", i), done, vecs[i].done);
        end

        // MAX_STEPS=4: four blocked steps exhaust the budget
        b_drive(1, 0);
        b_chk("b rst", 1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            b_drive(0, 3);
            b_chk($sformatf("b blk%0d", i), 1, 0, i, 1, (i == 4));
        end
        b_drive(0, 3);
        b_chk("b ignored5", 1, 0, 4, 0, 1);
        b_drive(0, 4);
        b_chk("b ignored6", 1, 0, 4, 0, 1);
        b_drive(1, 4);
        b_chk("b rst req", 1, 0, 0, 0, 0);
        chk("b rst zone", b_zone, 0);
        b_drive(0, 4);
        b_chk("b restart", 1, 1, 1, 0, 0);
        chk("b restart zone", b_zone, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
